stream_mux_rr: RTL and testbench

- Parametrised N-channel, WIDTH-bit streaming multiplexer with valid/ready handshakes on every input and on the output.
- Built-in arbiter: round-robin or fixed priority.
- Packet lock on `in_last`: a granted channel keeps the output until its last beat is accepted.
- Registered output stage, one beat per cycle. Sits between multiple producers (e.g. bus masters, debug/monitor sources) and a single consumer, replacing the static sel-driven muxes where the selection must be made at run time.

---
 rtl/stream_mux_rr.sv | 139 +++++++++++++
 tb/tb_stream_mux_rr.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with a built-in
// round-robin or fixed-priority arbiter, packet lock on in_last and a single
// registered output stage that sustains one beat per cycle.
module stream_mux_rr #(
    parameter int WIDTH     = 8,
    parameter int N         = 4,
    parameter int SELW      = 2,
    parameter int FIXED_PRI = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [SELW-1:0]  grant_q, grant_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;

    logic [WIDTH-1:0] ch_data [N];
    logic [SELW-1:0]  pick;
    logic             pick_found;
    logic [SELW:0]    rot_idx;
    logic [SELW-1:0]  cand;
    logic [SELW-1:0]  sel;
    logic             sel_valid;
    logic             space;
    logic             accept;
    logic [N-1:0]     ready_vec;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    // Arbiter: first valid channel from rr_ptr upward (wrapping), or lowest index in fixed mode.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        rot_idx    = '0;
        cand       = '0;
        for (int k = 0; k < N; k++) begin
            if (FIXED_PRI != 0) begin
                cand = SELW'(k);
            end else begin
                rot_idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
                if (rot_idx >= (SELW+1)'(N)) begin
                    rot_idx = rot_idx - (SELW+1)'(N);
                end
                cand = rot_idx[SELW-1:0];
            end
            if (!pick_found && in_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Handshake: the locked channel owns the output; otherwise the arbiter's pick does.
    always_comb begin
        space     = !out_valid_q || out_ready;
        sel       = (state_q == LOCKED) ? grant_q : pick;
        sel_valid = (state_q == LOCKED) ? in_valid[sel] : pick_found;
        ready_vec = '0;
        if (rst_n && space && ((state_q == LOCKED) || pick_found)) begin
            ready_vec[sel] = 1'b1;
        end
        accept = rst_n && space && sel_valid;
    end

    // Next state for packet lock, rr pointer and output register.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[sel];
            out_last_d  = in_last[sel];
            out_sel_d   = sel;
            if (in_last[sel]) begin
                // Packet complete: release the lock and move fairness past this channel.
                state_d = IDLE;
                if (FIXED_PRI == 0) begin
                    rr_ptr_d = (sel == SELW'(N-1)) ? '0 : sel + SELW'(1);
                end
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                grant_d = sel;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; an asynchronous reset drops any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign in_ready  = ready_vec;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: drives a round-robin and a fixed-priority instance with
// the same input streams and compares both against a per-packet behavioural
// model, a stimulus table and directed multi-cycle sequences.
module tb_stream_mux_rr;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_last;
    logic               out_ready;

    logic [N-1:0]       rr_ready, fp_ready;
    logic               rr_ov, fp_ov, rr_ol, fp_ol;
    logic [WIDTH-1:0]   rr_od, fp_od;
    logic [SELW-1:0]    rr_os, fp_os;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW), .FIXED_PRI(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rr_ready), .out_valid(rr_ov),
        .out_data(rr_od), .out_last(rr_ol), .out_sel(rr_os), .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW), .FIXED_PRI(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(fp_ready), .out_valid(fp_ov),
        .out_data(fp_od), .out_last(fp_ol), .out_sel(fp_os), .out_ready(out_ready)
    );

    // Model state per instance: index 0 = round-robin, 1 = fixed priority.
    // owner < 0 means no packet is in progress.
    int         m_owner [2];
    int         m_next  [2];
    bit         m_ov    [2];
    logic [7:0] m_od    [2];
    bit         m_ol    [2];
    int         m_os    [2];

    typedef struct {
        logic [N-1:0] vin;
        logic [N-1:0] last;
        logic         ordy;
        logic [N-1:0] exp_rdy;
        logic         exp_ov;
        logic [7:0]   exp_od;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void mdl_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_next[m]  = 0;
            m_ov[m]    = 1'b0;
            m_od[m]    = 8'h00;
            m_ol[m]    = 1'b0;
            m_os[m]    = 0;
        end
    endfunction

    // Channel entitled to the output this cycle, or -1.
    function automatic int mdl_owner(int m);
        if (m_owner[m] >= 0) return m_owner[m];
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m == 1) ? k : (m_next[m] + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] mdl_ready(int m);
        logic [N-1:0] r;
        int p;
        r = '0;
        p = mdl_owner(m);
        if (rst_n && p >= 0 && (!m_ov[m] || out_ready)) r[p] = 1'b1;
        return r;
    endfunction

    function automatic void mdl_clock(int m);
        int p;
        if (!rst_n) begin
            mdl_reset();
            return;
        end
        p = mdl_owner(m);
        if (p >= 0 && in_valid[p] && (!m_ov[m] || out_ready)) begin
            m_ov[m] = 1'b1;
            m_od[m] = in_data[p*WIDTH +: WIDTH];
            m_ol[m] = in_last[p];
            m_os[m] = p;
            if (in_last[p]) begin
                m_owner[m] = -1;
                m_next[m]  = (p + 1) % N;
            end else begin
                m_owner[m] = p;
            end
        end else if (m_ov[m] && out_ready) begin
            m_ov[m] = 1'b0;
        end
    endfunction

    // Compare both instances with the model, then advance one clock.
    task automatic step();
        #1;
        chk("rr_in_ready",  rr_ready, mdl_ready(0));
        chk("rr_out_valid", rr_ov,    m_ov[0]);
        chk("rr_out_data",  rr_od,    m_od[0]);
        chk("rr_out_last",  rr_ol,    m_ol[0]);
        chk("rr_out_sel",   rr_os,    m_os[0]);
        chk("fp_in_ready",  fp_ready, mdl_ready(1));
        chk("fp_out_valid", fp_ov,    m_ov[1]);
        chk("fp_out_data",  fp_od,    m_od[1]);
        chk("fp_out_last",  fp_ol,    m_ol[1]);
        chk("fp_out_sel",   fp_os,    m_os[1]);
        @(posedge clk);
        mdl_clock(0);
        mdl_clock(1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_data_default();
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
    endtask

    initial begin
        tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b0, 8'h00};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h10};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h11};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 8'h12};
        tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h13};
        tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h10};
        tbl[6]  = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 8'h11};
        tbl[7]  = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 8'h11};
        tbl[8]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h11};
        tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 8'h12};
        tbl[10] = '{4'h0, 4'h0, 1'b1, 4'b0000, 1'b1, 8'h13};
        tbl[11] = '{4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 8'h13};

        // Reset with every channel requesting.
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        out_ready = 1'b1;
        set_data_default();
        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_rr_ready", rr_ready, 4'b0000);
        chk("reset_rr_valid", rr_ov, 1'b0);
        chk("reset_rr_sel",   rr_os, 2'd0);
        chk("reset_fp_ready", fp_ready, 4'b0000);
        chk("reset_fp_valid", fp_ov, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: round-robin fairness then short backpressure and drain.
        for (int i = 0; i < 12; i++) begin
            in_valid  = tbl[i].vin;
            in_last   = tbl[i].last;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_ready", i), rr_ready, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_valid", i), rr_ov,    tbl[i].exp_ov);
            chk($sformatf("tbl%0d_data", i),  rr_od,    tbl[i].exp_od);
            step();
        end

        // Backpressure holding 8'h5A for five cycles.
        in_valid  = 4'b0001;
        in_last   = 4'hF;
        in_data[0 +: WIDTH] = 8'h5A;
        out_ready = 1'b1;
        step();
        in_valid  = 4'hF;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_data",  rr_od, 8'h5A);
            chk("bp_hold_ready", rr_ready, 4'b0000);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", rr_ready, 4'b0010);
        step();
        chk("bp_next_data", rr_od, 8'h11);
        set_data_default();

        // Packet lock on ch2 with a mid-packet gap.
        do_reset();
        in_valid = 4'b0010;
        in_last  = 4'b0010;
        step();
        in_valid = 4'b0111;
        in_last  = 4'b0011;
        in_data[2*WIDTH +: WIDTH] = 8'hA0;
        #1;
        chk("lock_first_ready", rr_ready, 4'b0100);
        step();
        in_valid = 4'b0011;
        #1;
        chk("lock_gap_ready", rr_ready, 4'b0100);
        chk("lock_a0", rr_od, 8'hA0);
        step();
        in_valid = 4'b0111;
        in_data[2*WIDTH +: WIDTH] = 8'hA1;
        #1;
        chk("lock_bubble", rr_ov, 1'b0);
        chk("lock_hold_ready", rr_ready, 4'b0100);
        step();
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        in_data[2*WIDTH +: WIDTH] = 8'hA2;
        in_data[3*WIDTH +: WIDTH] = 8'h33;
        #1;
        chk("lock_a1", rr_od, 8'hA1);
        step();
        #1;
        chk("lock_a2", rr_od, 8'hA2);
        chk("lock_a2_last", rr_ol, 1'b1);
        chk("lock_next_ch3", rr_ready, 4'b1000);
        step();
        chk("lock_ch3_sel", rr_os, 2'd3);
        set_data_default();

        // Fixed priority: ch1 and ch3 compete, ch1 always wins.
        in_valid = 4'b1010;
        in_last  = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fp_sel_ch1",   fp_os, 2'd1);
            chk("fp_ready_ch1", fp_ready, 4'b0010);
            step();
        end

        // Asynchronous reset between beats 2 and 3 of a 4-beat ch1 packet.
        do_reset();
        in_valid = 4'b0010;
        in_last  = 4'b0000;
        in_data[1*WIDTH +: WIDTH] = 8'hB0;
        step();
        in_data[1*WIDTH +: WIDTH] = 8'hB1;
        step();
        in_data[1*WIDTH +: WIDTH] = 8'hB2;
        #1;
        chk("arst_pre_valid", rr_ov, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rr_valid", rr_ov, 1'b0);
        chk("arst_fp_valid", fp_ov, 1'b0);
        chk("arst_ready",    rr_ready, 4'b0000);
        mdl_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'hF;
        in_last  = 4'hF;
        set_data_default();
        #1;
        chk("arst_restart_ch0", rr_ready, 4'b0001);
        step();

        // Random streams against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom_range(0, 15));
            in_last   = 4'($urandom_range(0, 15));
            in_data   = 32'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
